// File: rtl/tv80_alu16_seq_pkg.sv
// Shared definitions for the 16-bit arithmetic sequencer around the TV80 ALU:
// request opcodes, ALU_Op codes, FSM states, F register bit positions and
// the per-pass ALU_Op selection.
package tv80_alu16_seq_pkg;

  typedef enum logic [1:0] {
    OP_ADD16 = 2'b00,
    OP_ADC16 = 2'b01,
    OP_SBC16 = 2'b10,
    OP_SUB16 = 2'b11
  } req_op_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_ADC = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_SBC = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LO   = 2'b01,
    ST_HI   = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  localparam int Flag_C = 0;
  localparam int Flag_N = 1;
  localparam int Flag_P = 2;
  localparam int Flag_X = 3;
  localparam int Flag_H = 4;
  localparam int Flag_Y = 5;
  localparam int Flag_Z = 6;
  localparam int Flag_S = 7;

  // Low pass: plain ADD/SUB unless the op consumes the incoming carry.
  function automatic logic [3:0] alu_op_lo(input req_op_t op);
    case (op)
      OP_ADD16: alu_op_lo = ALU_ADD;
      OP_ADC16: alu_op_lo = ALU_ADC;
      OP_SBC16: alu_op_lo = ALU_SBC;
      default:  alu_op_lo = ALU_SUB;
    endcase
  endfunction

  // High pass: always chains the carry/borrow produced by the low pass.
  function automatic logic [3:0] alu_op_hi(input req_op_t op);
    case (op)
      OP_ADD16, OP_ADC16: alu_op_hi = ALU_ADC;
      default:            alu_op_hi = ALU_SBC;
    endcase
  endfunction

endpackage

// File: rtl/tv80_alu16_seq_if.sv
// Request/response handshake plus the full ALU connection of the sequencer.
// slave = the sequencer, master = the requester and the ALU it steers.
interface tv80_alu16_seq_if;
  import tv80_alu16_seq_pkg::*;

  logic        req_valid;
  logic        req_ready;
  req_op_t     req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [7:0]  req_f;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_q;
  logic [7:0]  rsp_f;

  logic [3:0]  alu_op;
  logic        alu_arith16;
  logic        alu_z16;
  logic [5:0]  alu_ir;
  logic [1:0]  alu_iset;
  logic [7:0]  alu_busa;
  logic [7:0]  alu_busb;
  logic [7:0]  alu_fin;
  logic [7:0]  alu_q;
  logic [7:0]  alu_fout;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_f, rsp_ready, alu_q, alu_fout,
    output req_ready, rsp_valid, rsp_q, rsp_f,
           alu_op, alu_arith16, alu_z16, alu_ir, alu_iset, alu_busa, alu_busb, alu_fin
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_f, rsp_ready, alu_q, alu_fout,
    input  req_ready, rsp_valid, rsp_q, rsp_f,
           alu_op, alu_arith16, alu_z16, alu_ir, alu_iset, alu_busa, alu_busb, alu_fin
  );

endinterface

// File: rtl/tv80_alu16_seq.sv
// Runs a 16-bit ADD/ADC/SBC/SUB as two passes through the 8-bit TV80 ALU:
// low byte first, then high byte with the low-pass flags as F_In so carry,
// half-carry and the 16-bit zero test chain across the byte boundary.
module tv80_alu16_seq
  import tv80_alu16_seq_pkg::*;
(
  input logic             clk,
  input logic             reset,
  tv80_alu16_seq_if.slave bus
);

  state_t      state_reg, state_next;
  req_op_t     op_reg;
  logic [15:0] a_reg, b_reg;
  logic [7:0]  f_reg;
  logic [7:0]  q_lo_reg, f_lo_reg;
  logic [15:0] rsp_q_reg;
  logic [7:0]  rsp_f_reg;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next state and ALU steering; the ALU sees all-zero inputs outside LO/HI.
  always_comb begin
    state_next      = state_reg;
    bus.alu_op      = 4'b0000;
    bus.alu_arith16 = 1'b0;
    bus.alu_z16     = 1'b0;
    bus.alu_busa    = 8'h00;
    bus.alu_busb    = 8'h00;
    bus.alu_fin     = 8'h00;
    case (state_reg)
      ST_IDLE: begin
        if (bus.req_valid) state_next = ST_LO;
      end
      ST_LO: begin
        bus.alu_op      = alu_op_lo(op_reg);
        bus.alu_arith16 = (op_reg == OP_ADD16);
        bus.alu_busa    = a_reg[7:0];
        bus.alu_busb    = b_reg[7:0];
        bus.alu_fin     = f_reg;
        state_next      = ST_HI;
      end
      ST_HI: begin
        bus.alu_op      = alu_op_hi(op_reg);
        bus.alu_arith16 = (op_reg == OP_ADD16);
        // Z of the high pass must also account for the low byte being zero.
        bus.alu_z16     = (op_reg != OP_ADD16);
        bus.alu_busa    = a_reg[15:8];
        bus.alu_busb    = b_reg[15:8];
        bus.alu_fin     = f_lo_reg;
        state_next      = ST_DONE;
      end
      ST_DONE: begin
        if (bus.rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Request capture, low-pass capture and result assembly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_reg    <= OP_ADD16;
      a_reg     <= 16'h0000;
      b_reg     <= 16'h0000;
      f_reg     <= 8'h00;
      q_lo_reg  <= 8'h00;
      f_lo_reg  <= 8'h00;
      rsp_q_reg <= 16'h0000;
      rsp_f_reg <= 8'h00;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.req_valid) begin
            op_reg <= bus.req_op;
            a_reg  <= bus.req_a;
            b_reg  <= bus.req_b;
            f_reg  <= bus.req_f;
          end
        end
        ST_LO: begin
          q_lo_reg <= bus.alu_q;
          f_lo_reg <= bus.alu_fout;
        end
        ST_HI: begin
          rsp_q_reg <= {bus.alu_q, q_lo_reg};
          rsp_f_reg <= bus.alu_fout;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = (state_reg == ST_IDLE);
  assign bus.rsp_valid = (state_reg == ST_DONE);
  assign bus.rsp_q     = rsp_q_reg;
  assign bus.rsp_f     = rsp_f_reg;
  assign bus.alu_ir    = 6'b000000;
  assign bus.alu_iset  = 2'b00;

endmodule
